// File: rtl/cpu_pkg.sv
// cpu_pkg: shared Mini-SRC encodings for the shift/rotate unit.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_rotate_seq_shift_step.sv
// shift_step: one-position shift/rotate of the accumulator for the selected op.
module shift_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb
        dout = (op == OP_SHR)  ? {1'b0, din[WIDTH-1:1]} :
               (op == OP_SHRA) ? {din[WIDTH-1], din[WIDTH-1:1]} :
               (op == OP_SHL)  ? {din[WIDTH-2:0], 1'b0} :
               (op == OP_ROR)  ? {din[0], din[WIDTH-1:1]} :
               (op == OP_ROL)  ? {din[WIDTH-2:0], din[WIDTH-1]} : din;

endmodule

// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: multi-cycle shift/rotate unit, one bit position per clock.
module shift_rotate_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int LW = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] eff;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] step;

    // Shifts saturate at WIDTH; rotates wrap modulo WIDTH; unknown ops pass through.
    always_comb
        eff = (op == OP_ROR || op == OP_ROL) ? CNT_W'(b[LW-1:0]) :
              (op == OP_SHR || op == OP_SHRA || op == OP_SHL) ?
                  ((b >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(b)) : '0;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op   (op_q),
        .din  (result),
        .dout (step)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
            op_q   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    result <= a;
                    count  <= eff;
                    op_q   <= op;
                    state  <= ST_RUN;
                    busy   <= 1'b1;
                end
            end else if (count != '0) begin
                result <= step;
                count  <= count - CNT_W'(1);
            end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/shift_rotate_seq.md
Name: shift_rotate_seq

Overview:
- Multi-cycle shift/rotate execution unit in the Mini-SRC datapath.
- Sits between the operand sources (Y register and bus, which drive A and B) and the Z-low result register. Its `done` pulse is the Zlo load strobe.
- Performs SHR, SHRA, SHL, ROR and ROL one bit position per clock.
- Replaces the combinational shift path so that shift cost is bounded to one bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation select, latched on accepted start.
- a  in  WIDTH  value to shift, latched on accepted start.
- b  in  WIDTH  shift amount, full 32-bit value, latched on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result is final; drives Zlo load enable.
- result  out  WIDTH  accumulator; holds the last result until the next accepted start.

Behaviour:
- Reset: clr low forces, immediately and asynchronously:
  - state=IDLE, busy=0, done=0, result=0, count=0.
  - Applies mid-operation too: the operation is abandoned and no done pulse is produced.
- Op encoding:
  - 000 SHR: zero fill from the MSB.
  - 001 SHRA: the MSB is replicated.
  - 010 SHL: zero fill from the LSB.
  - 011 ROR.
  - 100 ROL.
  - 101–111: pass-through; effective count is forced to 0.
- Effective count:
  - Shifts (SHR/SHRA/SHL): eff = min(b, 32). Any b ≥ 32 saturates to 32, giving 0 for SHR/SHL and all-sign-bits for SHRA.
  - Rotates: eff = b[4:0], i.e. b modulo 32.
- States:
  - IDLE: busy=0. On an edge with start=1:
    - result <= a, count <= eff, op latched, state <= RUN.
  - RUN: busy=1.
    - count≠0: result shifts/rotates by one position; count <= count-1.
    - count=0: state <= IDLE, done <= 1 for exactly one cycle.
- Latency:
  - Start sampled at edge k gives done high after edge k+eff+1; the operation takes eff+1 cycles.
  - b=0 or a pass-through op gives done after 1 cycle with result=a.
- done is registered. Outside the single pulse, done=0.
- start while busy=1 is ignored. The operands are not re-sampled.
- Back-to-back operation: start asserted in the cycle done=1 is accepted, because state is already IDLE. The new load happens at the next edge, so there is no bubble beyond the done cycle.
- result changes only on an accepted start or during RUN. It is stable and equal to the final value from the done cycle until the next accepted start.
- Inputs a, b and op may change freely after the accepting edge.
- No combinational path from the inputs to any output.

Decomposition:
- Shared package (cpu_pkg) holds:
  - op encoding constants: OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL.
  - state encoding: ST_IDLE, ST_RUN.
  - the WIDTH default.
- One natural sub-module: shift_step. It is combinational and computes the one-position shift/rotate of the accumulator for a given op. It is instantiated once and is independently unit-testable.
- The FSM, counter and saturation logic remain in shift_rotate_seq.

Test Plan:
- Basic SHRA: op=SHRA, a=0x80000010, b=4, start for 1 cycle → busy for 5 cycles; done one cycle; result=0xF8000001; busy=0 afterwards.
- SHR vs SHL, same a: SHR a=0x80000010, b=4 → 0x08000001. SHL a=0x00000001, b=31 → 0x80000000, with done exactly 32 cycles after the start edge.
- Saturation and modulo:
  - SHRA a=0x80000000, b=100 → 0xFFFFFFFF after 33 cycles.
  - SHR same operands → 0x00000000.
  - ROR a=0x0000000F, b=36 → 0xF0000000 after 5 cycles.
  - ROL a=0x80000001, b=1 → 0x00000003.
- Zero and pass-through:
  - b=0, op=SHL, a=0x12345678 → done 1 cycle after start, result=0x12345678.
  - op=111, b=9 → same: done after 1 cycle, result unchanged.
- Handshake edges:
  - start held high during RUN with different a → ignored; result matches the first operands.
  - start asserted on the done cycle → second operation runs immediately and yields its correct result.
- Reset mid-op: start SHL b=20, pull clr low asynchronously at cycle 7 → busy, done and result go to 0 at once. After release, no done pulse appears and a fresh start works normally.
